// File: rtl/audio_ctrl_pkg.sv
// Shared types and helpers for the audio level controller.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Gain the ramp heads for: zero when muted, otherwise the level's share of full scale.
  function automatic int unsigned target_gain(input int unsigned lvl,
                                              input logic        mute,
                                              input int unsigned levels,
                                              input int unsigned gain_w);
    int unsigned full;
    full = (32'd1 << gain_w) - 32'd1;
    if (mute) begin
      target_gain = 32'd0;
    end else begin
      target_gain = (lvl * full) / levels;
    end
  endfunction

  // Thermometer code: the lowest lvl bits set out of a bar of levels bits.
  function automatic logic [31:0] thermo(input int unsigned lvl,
                                         input int unsigned levels);
    logic [31:0] ones;
    ones   = (32'd1 << levels) - 32'd1;
    thermo = ones >> (levels - lvl);
  endfunction

endpackage

// File: rtl/audio_level_ctrl_key_repeat.sv
// Hold-to-repeat stepper for one button: a step on press, another after
// REPEAT_DELAY held cycles, then one every REPEAT_PERIOD cycles.
module key_repeat
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic hold_off,
  output logic step
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  rep_state_t       r_state;
  rep_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_prev;
  logic             r_step;
  logic             w_step_nxt;
  logic             w_release;

  // A released button or an active hold-off both abort any press in progress.
  assign w_release = hold_off | ~btn;

  // State, counter, edge-detect and step pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_prev  <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= btn;
      r_step  <= w_step_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_release) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_prev) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DELAY: begin
          if (r_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
            w_state_nxt = REPEAT;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (r_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
            w_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Step request: press edge in IDLE, or the counter reaching its interval.
  always_comb begin
    w_step_nxt = 1'b0;
    if (w_release) begin
      w_step_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_step_nxt = ~r_prev;
        DELAY:   w_step_nxt = (r_cnt == CNT_W'(REPEAT_DELAY - 1));
        REPEAT:  w_step_nxt = (r_cnt == CNT_W'(REPEAT_PERIOD - 1));
        default: w_step_nxt = 1'b0;
      endcase
    end
  end

  assign step = r_step;

endmodule

// File: rtl/audio_level_ctrl.sv
// Volume/mute controller: button stepping with auto-repeat, click-free gain
// ramp, per-channel PCM scaling and a thermometer LED bar.
module audio_level_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned LEVELS        = 5,
  parameter int unsigned RESET_LEVEL   = 3,
  parameter int unsigned CH            = 2,
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned GAIN_W        = 8,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned RAMP_DIV      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up,
  input  logic                       down,
  input  logic                       mute,
  input  logic                       in_valid,
  input  logic [CH*SAMPLE_W-1:0]     in_data,
  output logic                       out_valid,
  output logic [CH*SAMPLE_W-1:0]     out_data,
  output logic [$clog2(LEVELS+1)-1:0] level,
  output logic [GAIN_W-1:0]          gain,
  output logic                       ramping,
  output logic [LEVELS-1:0]          led
);

  localparam int unsigned LVL_W = $clog2(LEVELS + 1);
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [LVL_W-1:0]  r_level;
  logic [GAIN_W-1:0] r_gain;
  logic [DIV_W-1:0]  r_div;
  logic              r_out_valid;
  logic [GAIN_W-1:0] w_target;
  logic              w_hold;
  logic              w_up_step;
  logic              w_dn_step;

  // Mute or a simultaneous up+down press suspends all stepping.
  assign w_hold = mute | (up & down);

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rep_up (
    .clk     (clk),
    .rst     (rst),
    .btn     (up),
    .hold_off(w_hold),
    .step    (w_up_step)
  );

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rep_dn (
    .clk     (clk),
    .rst     (rst),
    .btn     (down),
    .hold_off(w_hold),
    .step    (w_dn_step)
  );

  // Level register: saturating steps, frozen while stepping is suspended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= LVL_W'(RESET_LEVEL);
    end else if (!w_hold && w_up_step && (r_level != LVL_W'(LEVELS))) begin
      r_level <= r_level + LVL_W'(1);
    end else if (!w_hold && w_dn_step && (r_level != LVL_W'(1))) begin
      r_level <= r_level - LVL_W'(1);
    end else begin
      r_level <= r_level;
    end
  end

  assign w_target = GAIN_W'(target_gain(32'(r_level), mute, LEVELS, GAIN_W));

  // Gain ramp: one step toward target per RAMP_DIV cycles; divider idles at target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gain <= {GAIN_W{1'b0}};
      r_div  <= {DIV_W{1'b0}};
    end else if (r_gain == w_target) begin
      r_div  <= {DIV_W{1'b0}};
    end else if (r_div == DIV_W'(RAMP_DIV - 1)) begin
      r_div  <= {DIV_W{1'b0}};
      r_gain <= (r_gain < w_target) ? (r_gain + GAIN_W'(1)) : (r_gain - GAIN_W'(1));
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Output strobe follows the input strobe by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [SAMPLE_W-1:0]        w_sample;
    logic signed [SAMPLE_W+GAIN_W-1:0] w_prod;
    logic                              w_unused_lsb;
    logic [SAMPLE_W-1:0]               r_out;

    // Gain is at most full scale, so the product always fits SAMPLE_W+GAIN_W bits;
    // dropping the low GAIN_W bits is the arithmetic right shift (floor).
    assign w_sample     = in_data[c*SAMPLE_W +: SAMPLE_W];
    assign w_prod       = w_sample * $signed({1'b0, r_gain});
    assign w_unused_lsb = ^w_prod[GAIN_W-1:0];

    // Scaled sample register, loaded only on a strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out <= {SAMPLE_W{1'b0}};
      end else if (in_valid) begin
        r_out <= w_prod[SAMPLE_W+GAIN_W-1:GAIN_W];
      end else begin
        r_out <= r_out;
      end
    end

    assign out_data[c*SAMPLE_W +: SAMPLE_W] = r_out;
  end

  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign gain      = r_gain;
  assign ramping   = (r_gain != w_target);
  assign led       = mute ? {LEVELS{1'b0}} : LEVELS'(thermo(32'(r_level), LEVELS));

endmodule

// File: tb/tb_audio_level_ctrl.sv
// Self-checking bench for audio_level_ctrl with a cycle-level reference model.
module tb_audio_level_ctrl;

  localparam int LV = 5;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int RDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, mute, in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic [7:0]  gain;
  logic        ramping;
  logic [4:0]  led;

  audio_level_ctrl #(
    .LEVELS(LV), .RESET_LEVEL(3), .CH(2), .SAMPLE_W(16), .GAIN_W(8),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RAMP_DIV(RDIV)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .mute(mute),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .level(level), .gain(gain), .ramping(ramping), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_level, m_gain, m_wait;
  bit m_pend_up, m_pend_dn, m_ov;
  bit m_act[2];
  int m_held[2];
  bit m_prev[2];
  int m_out[2];

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    int          e0;
    int          e1;
  } vec_t;
  vec_t vecs[5];

  function automatic int tgt(int lvl, bit mu);
    return mu ? 0 : (lvl * 255) / LV;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 3; m_gain = 0; m_wait = 0;
    m_pend_up = 0; m_pend_dn = 0; m_ov = 0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_held[k] = 0; m_prev[k] = 0; m_out[k] = 0;
    end
  endtask

  // A press steps at held-time 0, RD, RD+RP, RD+2RP, ...
  task automatic dir_step(input int k, input bit btn, input bit hold, output bit s);
    s = 0;
    if (hold || !btn) begin
      m_act[k] = 0;
    end else if (!m_act[k]) begin
      if (!m_prev[k]) begin
        m_act[k] = 1; m_held[k] = 0; s = 1;
      end
    end else begin
      m_held[k]++;
      if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0)) s = 1;
    end
    m_prev[k] = btn;
  endtask

  task automatic model_step(input bit u, input bit d, input bit m, input bit iv, input logic [31:0] data);
    bit hold;
    int t, nl;
    longint s, p;
    bit su, sd;
    hold = m || (u && d);
    t = tgt(m_level, m);
    nl = m_level;
    if (!hold && m_pend_up && m_level < LV) nl = m_level + 1;
    else if (!hold && m_pend_dn && m_level > 1) nl = m_level - 1;
    if (iv) begin
      for (int c = 0; c < 2; c++) begin
        s = longint'($signed(data[c*16 +: 16]));
        p = s * m_gain;
        m_out[c] = int'(p >>> 8);
      end
    end
    m_ov = iv;
    if (m_gain == t) begin
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == RDIV) begin
        m_wait = 0;
        m_gain = (m_gain < t) ? m_gain + 1 : m_gain - 1;
      end
    end
    dir_step(0, u, hold, su);
    dir_step(1, d, hold, sd);
    m_pend_up = su;
    m_pend_dn = sd;
    m_level = nl;
  endtask

  // Drive inputs at a falling edge, clock once, then compare at the next falling edge.
  task automatic tick(input bit u, input bit d, input bit m, input bit iv, input logic [31:0] data);
    up = u; down = d; mute = m; in_valid = iv; in_data = data;
    model_step(u, d, m, iv, data);
    @(posedge clk);
    @(negedge clk);
    chk("level", level, m_level);
    chk("gain", gain, m_gain);
    chk("ramping", ramping, (m_gain != tgt(m_level, mute)) ? 1 : 0);
    chk("led", led, mute ? 0 : ((1 << m_level) - 1));
    chk("out_valid", out_valid, m_ov);
    chk("out0", $signed(out_data[15:0]), m_out[0]);
    chk("out1", $signed(out_data[31:16]), m_out[1]);
  endtask

  task automatic idle(input int n, input bit m);
    for (int i = 0; i < n; i++) tick(0, 0, m, 0, 32'd0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    up = 0; down = 0; mute = 0; in_valid = 0; in_data = 32'd0;
    rst = 1'b1;
    #1;
    chk("rst_gain", gain, 0);
    chk("rst_level", level, 3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lv_before;
    bit u, d, m;
    int len;

    vecs[0] = '{16'h7FFF, 16'h8000, 19583, -19584};
    vecs[1] = '{16'h0000, 16'hFFFF, 0, -1};
    vecs[2] = '{16'h0100, 16'hFF00, 153, -153};
    vecs[3] = '{16'h03E8, 16'hFC18, 597, -598};
    vecs[4] = '{16'h0064, 16'h0001, 59, 0};

    rst = 1'b1; up = 0; down = 0; mute = 0; in_valid = 0; in_data = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("init_level", level, 3);
    chk("init_led", led, 5'b00111);
    chk("init_gain", gain, 0);
    chk("init_ramping", ramping, 1);
    chk("init_out_valid", out_valid, 0);

    // 1: ramp 0 -> 153 in 612 cycles
    idle(611, 0);
    chk("s1_gain_611", gain, 152);
    idle(1, 0);
    chk("s1_gain_612", gain, 153);
    chk("s1_ramping_done", ramping, 0);
    idle(388, 0);
    chk("s1_level", level, 3);
    chk("s1_led", led, 5'b00111);

    // 2: hold up, then tap down past the bottom
    tick(1, 0, 0, 0, 32'd0);
    chk("s2_level_c1", level, 3);
    tick(1, 0, 0, 0, 32'd0);
    chk("s2_level_c2", level, 4);
    for (int i = 0; i < 19; i++) tick(1, 0, 0, 0, 32'd0);
    chk("s2_level_c21", level, 4);
    tick(1, 0, 0, 0, 32'd0);
    chk("s2_level_c22", level, 5);
    for (int i = 0; i < 18; i++) tick(1, 0, 0, 0, 32'd0);
    chk("s2_level_sat", level, 5);
    idle(3, 0);
    for (int tap = 0; tap < 7; tap++) begin
      tick(0, 1, 0, 0, 32'd0);
      idle(3, 0);
      if (tap == 3) chk("s2_level_4taps", level, 1);
    end
    chk("s2_level_floor", level, 1);

    // restore level 3 and settle
    for (int tap = 0; tap < 2; tap++) begin
      tick(1, 0, 0, 0, 32'd0);
      idle(3, 0);
    end
    idle(700, 0);
    chk("s3_pre_gain", gain, 153);

    // 3: mute ramps down, taps ignored, unmute ramps back
    tick(0, 0, 1, 0, 32'd0);
    chk("s3_led_muted", led, 5'b00000);
    idle(611, 1);
    chk("s3_gain_muted", gain, 0);
    for (int tap = 0; tap < 3; tap++) begin
      tick(1, 0, 1, 0, 32'd0);
      idle(3, 1);
    end
    chk("s3_level_frozen", level, 3);
    idle(612, 0);
    chk("s3_gain_restored", gain, 153);

    // 4: both buttons held
    lv_before = int'(level);
    for (int i = 0; i < 50; i++) tick(1, 1, 0, 0, 32'd0);
    chk("s4_level_both", level, lv_before);
    idle(3, 0);

    // 5: datapath vectors at gain 153
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, {vecs[i].s1, vecs[i].s0});
      chk("s5_valid", out_valid, 1);
      chk("s5_out0", $signed(out_data[15:0]), vecs[i].e0);
      chk("s5_out1", $signed(out_data[31:16]), vecs[i].e1);
      tick(0, 0, 0, 0, $urandom());
      chk("s5_valid_low", out_valid, 0);
      chk("s5_hold0", $signed(out_data[15:0]), vecs[i].e0);
    end

    // random phase
    for (int seg = 0; seg < 120; seg++) begin
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) tick(u, d, m, $urandom_range(0, 1) == 1, $urandom());
    end

    // 6: reset mid-ramp and mid-repeat
    do_reset();
    idle(300, 0);
    for (int i = 0; i < 25; i++) tick(1, 0, 0, 1, $urandom());
    chk("s6_pre_gain", gain, 81);
    do_reset();
    idle(612, 0);
    chk("s6_gain", gain, 153);
    chk("s6_ramping", ramping, 0);
    chk("s6_level", level, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
